// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing with
// memory handshakes, bus watchdog and traps. Optional counters under CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int unsigned OPW     = 5,
    parameter int unsigned ALUW    = 5,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero_flag,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            trap_clear,
    output logic            imem_req,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_source,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            alu_src_b,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic [ALUW-1:0] alu_control,
    output logic [2:0]      state,
    output logic            trap,
    output logic [1:0]      trap_cause,
`ifdef CTRL_PERF_CNT_EN
    output logic            retire,
    output logic [CNTW-1:0] cycle_cnt,
    output logic [CNTW-1:0] instret_cnt
`else
    output logic            retire
`endif
);

    localparam int unsigned WCW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    if (OPW < 5 || ALUW < 5 || CNTW == 0) begin : g_bad_params
        $error("multicycle_ctrl_fsm: OPW and ALUW must be >= 5 and CNTW > 0");
    end

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_JAL
    } cls_t;

    // Opcode class; any set bit above bit 4 makes the opcode illegal.
    function automatic cls_t classify(input logic [OPW-1:0] op);
        cls_t c;
        c = C_ILL;
        if ((op >> 5) == '0) begin
            case (op[4:0])
                5'b00001, 5'b00010, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                5'b01000, 5'b01010, 5'b01011, 5'b01100, 5'b10100: c = C_R;
                5'b00011, 5'b01001: c = C_I;
                5'b01101:           c = C_LW;
                5'b01110:           c = C_SW;
                5'b10000:           c = C_BEQ;
                5'b10001:           c = C_BNE;
                5'b10010:           c = C_JAL;
                default:            c = C_ILL;
            endcase
        end
        return c;
    endfunction

    state_t           r_state;
    logic [OPW-1:0]   r_opcode_q;
    logic             r_zero_q;
    logic [WCW-1:0]   r_wait_cnt;
    logic [1:0]       r_trap_cause;

    state_t           w_next_state;
    cls_t             w_cls_q;
    cls_t             w_cls_in;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_illegal;
    logic [ALUW-1:0]  w_ex_alu;
    logic             w_ex_src_b;
    logic [1:0]       w_ex_reg_dst;

    assign w_cls_q    = classify(r_opcode_q);
    assign w_cls_in   = classify(opcode);
    assign state      = r_state;
    assign trap_cause = r_trap_cause;

    // ALU setup chosen in EXECUTE and held through MEMORY/WRITEBACK.
    always_comb begin
        w_ex_alu     = '0;
        w_ex_src_b   = 1'b0;
        w_ex_reg_dst = 2'b00;
        case (w_cls_q)
            C_R: begin
                w_ex_alu     = ALUW'(r_opcode_q[4:0]);
                w_ex_reg_dst = 2'b01;
            end
            C_I: begin
                w_ex_alu   = ALUW'(r_opcode_q[4:0]);
                w_ex_src_b = 1'b1;
            end
            C_LW, C_SW: begin
                w_ex_alu   = ALUW'(5'b00001);
                w_ex_src_b = 1'b1;
            end
            C_BEQ, C_BNE: w_ex_alu = ALUW'(5'b00010);
            default: ;
        endcase
    end

    // Next-state and control outputs.
    always_comb begin
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_source    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        alu_src_b    = 1'b0;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_control  = '0;
        trap         = 1'b0;
        retire       = 1'b0;
        w_next_state = r_state;
        w_waiting    = 1'b0;
        w_timeout    = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_waiting = 1'b1;
                    if (TIMEOUT != 0 && r_wait_cnt == WCW'(TO_LAST)) begin
                        w_timeout    = 1'b1;
                        w_next_state = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                if (w_cls_in == C_ILL) begin
                    w_illegal    = 1'b1;
                    w_next_state = S_TRAP;
                end else begin
                    w_next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_control = w_ex_alu;
                alu_src_b   = w_ex_src_b;
                reg_dst     = w_ex_reg_dst;
                case (w_cls_q)
                    C_LW, C_SW: w_next_state = S_MEMORY;
                    C_JAL: begin
                        pc_write     = 1'b1;
                        pc_source    = 1'b1;
                        reg_write    = 1'b1;
                        reg_dst      = 2'b10;
                        mem_to_reg   = 2'b10;
                        retire       = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    default: w_next_state = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                alu_control = w_ex_alu;
                alu_src_b   = w_ex_src_b;
                mem_read    = (w_cls_q == C_LW);
                mem_write   = (w_cls_q == C_SW);
                if (dmem_ready) begin
                    w_next_state = S_WRITEBACK;
                end else begin
                    w_waiting = 1'b1;
                    if (TIMEOUT != 0 && r_wait_cnt == WCW'(TO_LAST)) begin
                        w_timeout    = 1'b1;
                        w_next_state = S_TRAP;
                    end
                end
            end
            S_WRITEBACK: begin
                alu_control  = w_ex_alu;
                alu_src_b    = w_ex_src_b;
                reg_dst      = w_ex_reg_dst;
                retire       = 1'b1;
                w_next_state = S_FETCH;
                case (w_cls_q)
                    C_R, C_I: reg_write = 1'b1;
                    C_LW: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b01;
                    end
                    C_BEQ: begin
                        pc_write  = r_zero_q;
                        pc_source = r_zero_q;
                    end
                    C_BNE: begin
                        pc_write  = ~r_zero_q;
                        pc_source = ~r_zero_q;
                    end
                    default: ;
                endcase
            end
            S_TRAP: begin
                trap = 1'b1;
                if (trap_clear) w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_opcode_q   <= '0;
            r_zero_q     <= 1'b0;
            r_wait_cnt   <= '0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE)  r_opcode_q <= opcode;
            if (r_state == S_EXECUTE) r_zero_q   <= zero_flag;
            // Watchdog restarts on any state change or once the awaited ready shows up.
            if (w_next_state != r_state || !w_waiting || TIMEOUT == 0) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
            if (w_illegal)      r_trap_cause <= 2'b01;
            else if (w_timeout) r_trap_cause <= 2'b10;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (r_state != S_TRAP) cycle_cnt   <= cycle_cnt + CNTW'(1);
            if (retire)            instret_cnt <= instret_cnt + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic        zero_flag, imem_ready, dmem_ready, trap_clear;
    logic        imem_req, ir_write, pc_write, pc_source, mem_read, mem_write;
    logic        reg_write, alu_src_b, trap, retire;
    logic [1:0]  reg_dst, mem_to_reg, trap_cause;
    logic [4:0]  alu_control;
    logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPW(5), .ALUW(5), .TIMEOUT(15), .CNTW(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_clear(trap_clear),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_source(pc_source), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_control(alu_control), .state(state),
        .trap(trap), .trap_cause(trap_cause),
`ifdef CTRL_PERF_CNT_EN
        .retire(retire), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`else
        .retire(retire)
`endif
    );

    // ctl = {imem_req, ir_write, pc_write, pc_source, mem_read, mem_write, reg_write,
    //        alu_src_b, retire, trap, reg_dst[1:0], mem_to_reg[1:0]}
    localparam logic [13:0] F_WAIT = 14'b1000_0000_00_00_00;
    localparam logic [13:0] F_GO   = 14'b1110_0000_00_00_00;
    localparam logic [13:0] NONE   = 14'b0000_0000_00_00_00;
    localparam logic [13:0] TRAPC  = 14'b0000_0000_01_00_00;
    localparam logic [13:0] EX_R   = 14'b0000_0000_00_01_00;
    localparam logic [13:0] WB_R   = 14'b0000_0010_10_01_00;
    localparam logic [13:0] ADDR   = 14'b0000_0001_00_00_00;
    localparam logic [13:0] MEM_RD = 14'b0000_1001_00_00_00;
    localparam logic [13:0] MEM_WR = 14'b0000_0101_00_00_00;
    localparam logic [13:0] WB_LW  = 14'b0000_0011_10_00_01;
    localparam logic [13:0] WB_I   = 14'b0000_0011_10_00_00;
    localparam logic [13:0] WB_SW  = 14'b0000_0001_10_00_00;
    localparam logic [13:0] WB_BRT = 14'b0011_0000_10_00_00;
    localparam logic [13:0] WB_BRN = 14'b0000_0000_10_00_00;
    localparam logic [13:0] EX_JAL = 14'b0011_0010_10_10_10;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADDI = 5'b00011;
    localparam logic [4:0] OP_LW   = 5'b01101;
    localparam logic [4:0] OP_SW   = 5'b01110;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BNE  = 5'b10001;
    localparam logic [4:0] OP_JAL  = 5'b10010;
    localparam logic [4:0] OP_ILL  = 5'b11111;

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] ctl;
        logic [4:0]  alu;
        logic [1:0]  tc;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    exp_t        m_e;
    string       m_name;
    logic [13:0] m_ctl;

    // Drive one cycle of inputs, queue what the DUT must show, then advance.
    task automatic cyc(input string nm, input logic rst, input logic [4:0] op,
                       input logic zf, input logic ir, input logic dr, input logic tclr,
                       input logic [2:0] st, input logic [13:0] ctl,
                       input logic [4:0] alu, input logic [1:0] tc);
        exp_t e;
        reset = rst; opcode = op; zero_flag = zf;
        imem_ready = ir; dmem_ready = dr; trap_clear = tclr;
        e.st = st; e.ctl = ctl; e.alu = alu; e.tc = tc;
        q_exp.push_back(e);
        q_name.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_exp.size() != 0) begin
            m_e    = q_exp.pop_front();
            m_name = q_name.pop_front();
            m_ctl  = {imem_req, ir_write, pc_write, pc_source, mem_read, mem_write,
                      reg_write, alu_src_b, retire, trap, reg_dst, mem_to_reg};
            n_cmp++;
            if (state !== m_e.st || m_ctl !== m_e.ctl || alu_control !== m_e.alu
                || trap_cause !== m_e.tc) begin
                n_bad++;
                $display("FAIL %s: got state=%0d ctl=%b alu=%b cause=%b, want state=%0d ctl=%b alu=%b cause=%b",
                         m_name, state, m_ctl, alu_control, trap_cause,
                         m_e.st, m_e.ctl, m_e.alu, m_e.tc);
            end
        end
    end

    initial begin
        reset = 1'b1; opcode = '0; zero_flag = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; trap_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        cyc("reset",    0, 5'd0,    0, 0, 0, 0, 3'd0, F_WAIT, 5'd0, 2'b00);

        cyc("add_f",    0, OP_ADD,  0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("add_d",    0, OP_ADD,  0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("add_e",    0, OP_ADD,  0, 1, 1, 0, 3'd2, EX_R,   5'd1, 2'b00);
        cyc("add_w",    0, OP_ADD,  0, 1, 1, 0, 3'd4, WB_R,   5'd1, 2'b00);

        cyc("lw_f",     0, OP_LW,   0, 1, 0, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("lw_d",     0, OP_LW,   0, 1, 0, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("lw_e",     0, OP_LW,   0, 1, 0, 0, 3'd2, ADDR,   5'd1, 2'b00);
        for (int i = 0; i < 3; i++)
            cyc("lw_mwait", 0, OP_LW, 0, 1, 0, 0, 3'd3, MEM_RD, 5'd1, 2'b00);
        cyc("lw_m",     0, OP_LW,   0, 1, 1, 0, 3'd3, MEM_RD, 5'd1, 2'b00);
        cyc("lw_w",     0, OP_LW,   0, 1, 1, 0, 3'd4, WB_LW,  5'd1, 2'b00);

        cyc("beq_f",    0, OP_BEQ,  0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("beq_d",    0, OP_BEQ,  0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("beq_e",    0, OP_BEQ,  1, 1, 1, 0, 3'd2, NONE,   5'd2, 2'b00);
        cyc("beq_w",    0, OP_BEQ,  0, 1, 1, 0, 3'd4, WB_BRT, 5'd2, 2'b00);

        cyc("bne_f",    0, OP_BNE,  0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("bne_d",    0, OP_BNE,  0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("bne_e",    0, OP_BNE,  1, 1, 1, 0, 3'd2, NONE,   5'd2, 2'b00);
        cyc("bne_w",    0, OP_BNE,  1, 1, 1, 0, 3'd4, WB_BRN, 5'd2, 2'b00);

        cyc("sw_f",     0, OP_SW,   0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("sw_d",     0, OP_SW,   0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("sw_e",     0, OP_SW,   0, 1, 1, 0, 3'd2, ADDR,   5'd1, 2'b00);
        cyc("sw_m",     0, OP_SW,   0, 1, 1, 0, 3'd3, MEM_WR, 5'd1, 2'b00);
        cyc("sw_w",     0, OP_SW,   0, 1, 1, 0, 3'd4, WB_SW,  5'd1, 2'b00);

        cyc("addi_f",   0, OP_ADDI, 0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("addi_d",   0, OP_ADDI, 0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("addi_e",   0, OP_ADDI, 0, 1, 1, 0, 3'd2, ADDR,   5'd3, 2'b00);
        cyc("addi_w",   0, OP_ADDI, 0, 1, 1, 0, 3'd4, WB_I,   5'd3, 2'b00);

        // Illegal opcode: trap with ready inputs high that must be ignored.
        cyc("ill_f",    0, OP_ILL,  0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("ill_d",    0, OP_ILL,  0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("ill_trap", 0, OP_ILL,  0, 1, 1, 0, 3'd5, TRAPC,  5'd0, 2'b01);
        cyc("ill_clr",  0, OP_ILL,  0, 1, 1, 1, 3'd5, TRAPC,  5'd0, 2'b01);

        // Watchdog: 15 FETCH cycles with no ready, then TRAP with bus timeout.
        for (int i = 0; i < 15; i++)
            cyc("to_fetch", 0, 5'd0, 0, 0, 0, 0, 3'd0, F_WAIT, 5'd0, 2'b01);
        cyc("to_trap",  0, 5'd0,    0, 0, 0, 1, 3'd5, TRAPC,  5'd0, 2'b10);

        // Ready arriving on the last allowed cycle wins.
        for (int i = 0; i < 14; i++)
            cyc("nm_fetch", 0, OP_JAL, 0, 0, 0, 0, 3'd0, F_WAIT, 5'd0, 2'b10);
        cyc("nm_go",    0, OP_JAL,  0, 1, 0, 0, 3'd0, F_GO,   5'd0, 2'b10);
        cyc("nm_d",     0, OP_JAL,  0, 1, 0, 0, 3'd1, NONE,   5'd0, 2'b10);
        cyc("nm_jal",   0, OP_JAL,  0, 1, 0, 0, 3'd2, EX_JAL, 5'd0, 2'b10);

        // Reset mid-MEMORY drops the read request immediately and clears the cause.
        cyc("rl_f",     0, OP_LW,   0, 1, 0, 0, 3'd0, F_GO,   5'd0, 2'b10);
        cyc("rl_d",     0, OP_LW,   0, 1, 0, 0, 3'd1, NONE,   5'd0, 2'b10);
        cyc("rl_e",     0, OP_LW,   0, 1, 0, 0, 3'd2, ADDR,   5'd1, 2'b10);
        cyc("rl_m",     0, OP_LW,   0, 1, 0, 0, 3'd3, MEM_RD, 5'd1, 2'b10);
        cyc("rl_rst",   1, OP_LW,   0, 0, 0, 0, 3'd0, F_WAIT, 5'd0, 2'b00);

        cyc("jal_f",    0, OP_JAL,  0, 1, 1, 0, 3'd0, F_GO,   5'd0, 2'b00);
        cyc("jal_d",    0, OP_JAL,  0, 1, 1, 0, 3'd1, NONE,   5'd0, 2'b00);
        cyc("jal_e",    0, OP_JAL,  0, 1, 1, 0, 3'd2, EX_JAL, 5'd0, 2'b00);
`ifdef CTRL_PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 32'd3 || instret_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL perf_cnt: got cycle=%0d instret=%0d, want cycle=3 instret=1",
                     cycle_cnt, instret_cnt);
        end
`endif
        cyc("post_jal", 0, 5'd0,    0, 0, 0, 0, 3'd0, F_WAIT, 5'd0, 2'b00);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
